work_loader: RTL and testbench
==============================

Name: work_loader

Overview:
- Host-side front end that sits directly upstream of the SHA mining core.
- Receives a byte stream from the UART receiver and packs it into 32-bit words.
- Drives the core's start_found, in_data and shift_in_enable inputs for 8 midstate words followed by 16 header words.
- Waits for the core's solution claim, returns the 32-bit golden nonce to the host byte-serially, then acknowledges the core with sol_response.

Parameters:
- START_BYTE, 8'hA5: framing byte that begins a new work unit.
- MID_WORDS, 8: number of midstate words per work unit.
- HEAD_WORDS, 16: number of header words per work unit.
- TIMEOUT_CYCLES, 1000000: inter-byte timeout in LOAD. Used only with WORK_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- n_rst  input  1  asynchronous, active-low reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- tx_data  output  8  nonce byte to the UART transmitter
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  transmitter accepts the byte when tx_valid && tx_ready
- start_found  output  1  one-cycle pulse to the core: new work is starting
- in_data  output  32  word presented to the core's shift registers
- shift_in_enable  output  1  one-cycle pulse: in_data is valid to shift in
- sol_claim  input  1  core has found a nonce (level)
- out_data  input  32  golden nonce from the core; valid while sol_claim is high
- sol_response  output  1  one-cycle acknowledge to the core
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: clk is the only clock; reset is async active-low on n_rst. Asserting reset forces state=IDLE and clears all outputs to 0: tx_data=0, tx_valid=0, start_found=0, in_data=0, shift_in_enable=0, sol_response=0, busy=0. Byte/word counters and the nonce register are also cleared. Reset mid-operation abandons the work unit with no partial output.
- FSM states: IDLE, LOAD, SOLVE, REPORT, ACK.
- IDLE:
  - rx_valid && rx_data==START_BYTE at cycle N → start_found=1 at N+1 (exactly one cycle); state=LOAD; counters cleared.
  - Any other byte is discarded.
- LOAD:
  - Bytes are packed big-endian: the first byte goes to [31:24].
  - The 4th byte accepted at cycle N → in_data=packed word and shift_in_enable=1 at N+1 for one cycle. in_data holds its value until the next word.
  - Words 0..MID_WORDS-1 are midstate; the next HEAD_WORDS words are header. The word counter is 5 bits.
  - After word MID_WORDS+HEAD_WORDS-1 (the 24th) is emitted → SOLVE.
  - In LOAD, START_BYTE is plain data; there is no escaping.
- SOLVE:
  - sol_claim=1 at cycle N → out_data is captured into the nonce register; state=REPORT.
  - rx START_BYTE while sol_claim=0 → abort: start_found pulses, state=LOAD (re-work).
  - sol_claim and START_BYTE in the same cycle → sol_claim wins and the byte is dropped.
- REPORT:
  - Sends 4 bytes, MSB first. tx_valid=1 from N+1 (N = claim cycle).
  - tx_data is stable while tx_valid && !tx_ready. Each byte advances only on a tx_valid && tx_ready handshake, so back-to-back ready gives 4 consecutive cycles.
  - rx bytes are ignored in this state.
- ACK: entered after the 4th byte is accepted. tx_valid=0; sol_response=1 for one cycle; next state is IDLE.
- Core latency: shift_in_enable pulses are at least 4 cycles apart, set by the byte rate.

Optional Feature:
- Macro: WORK_TIMEOUT_EN.
- Defined:
  - A counter in LOAD counts cycles since the last accepted byte; it resets on each rx_valid.
  - On reaching TIMEOUT_CYCLES-1: state=IDLE, partial word discarded, no shift_in_enable.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter; LOAD waits indefinitely.

Decomposition:
- Package work_loader_pkg holds:
  - the state enum type (IDLE, LOAD, SOLVE, REPORT, ACK);
  - the START_BYTE default;
  - MID_WORDS and HEAD_WORDS defaults;
  - the TOTAL_WORDS constant (24).
- One sub-module, nonce_serializer:
  - loads 32 bits on a load pulse;
  - runs the tx_valid/tx_ready handshake for 4 bytes MSB first;
  - raises done for one cycle after the last byte.

Test Plan:
- Reset: hold n_rst=0 for 3 cycles mid-LOAD, then release → all outputs 0, busy=0; no shift pulses until a new A5.
- Load: bytes A5, then 96 bytes 00,01,..,5F → start_found once; 24 shift_in_enable pulses; word0=00010203, word23=5C5D5E5F; busy stays high in SOLVE.
- Report: sol_claim=1 with out_data=DEADBEEF; tx_ready low for 2 cycles then high → tx_data DE held, then DE,AD,BE,EF in order; sol_response pulses one cycle; state returns to IDLE.
- Collision and abort: in SOLVE, sol_claim and A5 arrive in the same cycle → nonce is reported and start_found does not pulse. A separate A5 in SOLVE with no claim → start_found pulses and reload begins.
- Noise: bytes 00, FF in IDLE → no start_found and no shift pulses.
- Timeout (WORK_TIMEOUT_EN, TIMEOUT_CYCLES=16): A5 plus 2 bytes, then 16 idle cycles → IDLE, no shift_in_enable. A subsequent A5 restarts the load.

Source files
------------

// File: rtl/work_loader_pkg.sv
// Shared types and defaults for the work_loader host front end.
// The inter-byte timeout is enabled with the WORK_TIMEOUT_EN macro.
package work_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SOLVE  = 3'd2,
        REPORT = 3'd3,
        ACK    = 3'd4
    } state_e;

    localparam logic [7:0] START_BYTE_DEF = 8'hA5;
    localparam int         MID_WORDS_DEF  = 8;
    localparam int         HEAD_WORDS_DEF = 16;
    localparam int         TOTAL_WORDS    = MID_WORDS_DEF + HEAD_WORDS_DEF;

endpackage

// File: rtl/work_loader_nonce_serializer.sv
// Sends a 32-bit nonce as four bytes, MSB first, over a valid/ready link.
// done_o pulses for one cycle after the last byte has been accepted.
module nonce_serializer (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load_i,
    input  logic [31:0] nonce_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        done_o
);

    logic [31:0] data_q, data_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    // Handshake: a byte transfers on any cycle with tx_valid_o && tx_ready_i;
    // until then tx_valid_o stays high and tx_data_o does not change.
    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (load_i) begin
            data_d  = nonce_i;
            cnt_d   = 2'd0;
            valid_d = 1'b1;
        end else if (valid_q && tx_ready_i) begin
            data_d = {data_q[23:0], 8'h00};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign tx_data_o  = data_q[31:24];
    assign tx_valid_o = valid_q;
    assign done_o     = done_q;

endmodule

// File: rtl/work_loader.sv
// Packs UART bytes into midstate/header words for the SHA core and returns
// the golden nonce to the host. WORK_TIMEOUT_EN adds an inter-byte timeout in LOAD.
module work_loader
  import work_loader_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] START_BYTE = START_BYTE_DEF,
  parameter int         MID_WORDS  = MID_WORDS_DEF,
  parameter int         HEAD_WORDS = HEAD_WORDS_DEF
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        start_found,
  output logic [31:0] in_data,
  output logic        shift_in_enable,
  input  logic        sol_claim,
  input  logic [31:0] out_data,
  output logic        sol_response,
  output logic        busy,
  output state_e      state_o
);

  localparam logic [4:0] LAST_WORD = 5'(MID_WORDS + HEAD_WORDS - 1);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [4:0]  word_cnt_q, word_cnt_d;
  logic [23:0] acc_q, acc_d;
  logic [31:0] in_data_q, in_data_d;
  logic        shift_en_q, shift_en_d;
  logic        start_q, start_d;
  logic        ser_load;
  logic        ser_done;
  logic        rx_start;

  assign rx_start = rx_valid && (rx_data == START_BYTE);

`ifdef WORK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  // Counts idle cycles only while loading; any accepted byte restarts it.
  assign tmo_d   = (state_q != LOAD || rx_valid) ? '0 : tmo_q + 1'b1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    acc_d      = acc_q;
    in_data_d  = in_data_q;
    shift_en_d = 1'b0;
    start_d    = 1'b0;
    ser_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_start) begin
          start_d    = 1'b1;
          state_d    = LOAD;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          acc_d      = '0;
        end
      end
      LOAD: begin
        // START_BYTE is ordinary payload here; bytes pack big-endian.
        if (rx_valid) begin
          if (byte_cnt_q == 2'd3) begin
            in_data_d  = {acc_q, rx_data};
            shift_en_d = 1'b1;
            byte_cnt_d = '0;
            word_cnt_d = word_cnt_q + 5'd1;
            if (word_cnt_q == LAST_WORD) begin
              state_d = SOLVE;
            end
          end else begin
            acc_d      = {acc_q[15:0], rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
`ifdef WORK_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = IDLE;
        end
`endif
      end
      SOLVE: begin
        // A claim outranks a simultaneous start byte, which is dropped.
        if (sol_claim) begin
          ser_load = 1'b1;
          state_d  = REPORT;
        end else if (rx_start) begin
          start_d    = 1'b1;
          state_d    = LOAD;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          acc_d      = '0;
        end
      end
      REPORT: begin
        if (ser_done) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      acc_q      <= '0;
      in_data_q  <= '0;
      shift_en_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      acc_q      <= acc_d;
      in_data_q  <= in_data_d;
      shift_en_q <= shift_en_d;
      start_q    <= start_d;
    end
  end

  nonce_serializer u_ser (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (ser_load),
    .nonce_i    (out_data),
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .done_o     (ser_done)
  );

  assign start_found     = start_q;
  assign in_data         = in_data_q;
  assign shift_in_enable = shift_en_q;
  assign sol_response    = (state_q == ACK);
  assign busy            = (state_q != IDLE);
  assign state_o         = state_q;

endmodule

// File: tb/tb_work_loader.sv
// Self-checking bench for work_loader: noise/report tables plus hand-written
// reset, abort and (with WORK_TIMEOUT_EN) timeout sequences.
module tb_work_loader;
  import work_loader_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic        sol_claim = 1'b0;
  logic [31:0] out_data = 32'h0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        start_found;
  logic [31:0] in_data;
  logic        shift_in_enable;
  logic        sol_response;
  logic        busy;
  state_e      state;

  always #5 clk = ~clk;

  work_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .start_found     (start_found),
    .in_data         (in_data),
    .shift_in_enable (shift_in_enable),
    .sol_claim       (sol_claim),
    .out_data        (out_data),
    .sol_response    (sol_response),
    .busy            (busy),
    .state_o         (state)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [31:0] got_words[$];
  int          start_cnt = 0;
  int          shift_cnt = 0;
  int          resp_cnt = 0;
  logic        hold_prev = 1'b0;
  logic [7:0]  data_prev = 8'h00;

  typedef struct {
    logic [7:0] b;
    int         exp_start;
  } noise_t;

  typedef struct {
    logic [31:0] nonce;
    int          stall;
    bit          collide;
    logic [7:0]  base;
  } rep_t;

  noise_t noise_tab[5];
  rep_t   rep_tab[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: pops expected words/bytes as the DUT produces them.
  always @(negedge clk) begin
    if (!n_rst) begin
      hold_prev <= 1'b0;
    end else begin
      if (start_found) start_cnt <= start_cnt + 1;
      if (sol_response) resp_cnt <= resp_cnt + 1;
      if (shift_in_enable) begin
        shift_cnt <= shift_cnt + 1;
        got_words.push_back(in_data);
        if (exp_q.size() == 0) check("shift_unexpected", 32'd1, 32'd0);
        else check("in_data", in_data, exp_q.pop_front());
      end
      if (hold_prev && tx_valid) check("tx_hold", {24'h0, tx_data}, {24'h0, data_prev});
      if (tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
        else check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
      end
      hold_prev <= tx_valid && !tx_ready;
      data_prev <= tx_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom_range(0, 255));
    repeat ($urandom_range(0, 2)) tick(1);
  endtask

  task automatic load_words(input logic [7:0] base, input int nwords);
    logic [7:0] b;
    for (int w = 0; w < nwords; w++) begin
      logic [31:0] word;
      for (int k = 0; k < 4; k++) begin
        b = base + 8'(4 * w + k);
        word = {word[23:0], b};
      end
      exp_q.push_back(word);
      for (int k = 0; k < 4; k++) send_byte(word[31 - 8 * k -: 8]);
    end
  endtask

  task automatic do_report(input rep_t r, input string tag);
    int s0;
    int r0;
    s0 = start_cnt;
    r0 = resp_cnt;
    for (int k = 0; k < 4; k++) exp_tx_q.push_back(r.nonce[31 - 8 * k -: 8]);
    out_data  = r.nonce;
    sol_claim = 1'b1;
    tx_ready  = (r.stall == 0);
    if (r.collide) begin
      rx_data  = START_BYTE_DEF;
      rx_valid = 1'b1;
    end
    tick(1);
    sol_claim = 1'b0;
    rx_valid  = 1'b0;
    out_data  = $urandom;
    check({tag, "_tx_valid_rise"}, {31'h0, tx_valid}, 32'd1);
    check({tag, "_state_report"}, {29'h0, state}, {29'h0, REPORT});
    if (r.collide) send_byte(START_BYTE_DEF);
    if (r.stall > 0) begin
      tick(r.stall);
      tx_ready = 1'b1;
    end
    for (int c = 0; c < 40 && resp_cnt == r0; c++) tick(1);
    tick(3);
    tx_ready = 1'b0;
    check({tag, "_sol_response_pulses"}, resp_cnt - r0, 32'd1);
    check({tag, "_no_start"}, start_cnt - s0, 32'd0);
    check({tag, "_tx_left"}, exp_tx_q.size(), 32'd0);
    check({tag, "_state_idle"}, {29'h0, state}, {29'h0, IDLE});
    check({tag, "_busy_low"}, {31'h0, busy}, 32'd0);
    check({tag, "_tx_valid_low"}, {31'h0, tx_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, {24'h0, tx_data}, 32'd0);
    check({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'd0);
    check({tag, "_start_found"}, {31'h0, start_found}, 32'd0);
    check({tag, "_in_data"}, in_data, 32'd0);
    check({tag, "_shift_in_enable"}, {31'h0, shift_in_enable}, 32'd0);
    check({tag, "_sol_response"}, {31'h0, sol_response}, 32'd0);
    check({tag, "_busy"}, {31'h0, busy}, 32'd0);
    check({tag, "_state"}, {29'h0, state}, {29'h0, IDLE});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0;
    int sh0;
    noise_tab = '{'{8'h00, 0}, '{8'hFF, 0}, '{8'h5A, 0}, '{8'hA4, 0}, '{8'hA5, 1}};
    rep_tab   = '{'{32'hDEADBEEF, 2, 1'b0, 8'h00},
                  '{32'h01A5FF80, 0, 1'b1, 8'h40},
                  '{32'h12345678, 3, 1'b0, 8'hC0}};

    // Clock/reset
    tick(3);
    check_reset_outputs("por");
    n_rst = 1'b1;
    tick(2);

    // Noise in IDLE; the final A5 row starts a work unit
    for (int i = 0; i < 5; i++) begin
      s0  = start_cnt;
      sh0 = shift_cnt;
      send_byte(noise_tab[i].b);
      tick(2);
      check($sformatf("noise_start_%0d", i), start_cnt - s0, noise_tab[i].exp_start);
      check($sformatf("noise_shift_%0d", i), shift_cnt - sh0, 32'd0);
      check($sformatf("noise_busy_%0d", i), {31'h0, busy}, noise_tab[i].exp_start);
    end

    // Full load 00..5F
    got_words.delete();
    sh0 = shift_cnt;
    s0  = start_cnt;
    load_words(8'h00, TOTAL_WORDS);
    tick(3);
    check("load_shift_count", shift_cnt - sh0, TOTAL_WORDS);
    check("load_no_extra_start", start_cnt - s0, 32'd0);
    if (got_words.size() == TOTAL_WORDS) begin
      check("load_word0", got_words[0], 32'h00010203);
      check("load_word23", got_words[23], 32'h5C5D5E5F);
    end else begin
      check("load_words_seen", got_words.size(), TOTAL_WORDS);
    end
    check("load_state_solve", {29'h0, state}, {29'h0, SOLVE});
    check("load_busy_solve", {31'h0, busy}, 32'd1);
    check("load_in_data_hold", in_data, 32'h5C5D5E5F);

    // Report table (row 0 uses the work already loaded)
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        s0 = start_cnt;
        send_byte(START_BYTE_DEF);
        load_words(rep_tab[i].base, TOTAL_WORDS);
        tick(2);
        check($sformatf("rep%0d_start", i), start_cnt - s0, 32'd1);
        check($sformatf("rep%0d_solve", i), {29'h0, state}, {29'h0, SOLVE});
      end
      do_report(rep_tab[i], $sformatf("rep%0d", i));
    end

    // Abort from SOLVE with a fresh start byte, then reload
    send_byte(START_BYTE_DEF);
    load_words(8'h80, TOTAL_WORDS);
    tick(2);
    check("abort_pre_solve", {29'h0, state}, {29'h0, SOLVE});
    s0 = start_cnt;
    send_byte(START_BYTE_DEF);
    tick(1);
    check("abort_start", start_cnt - s0, 32'd1);
    check("abort_state_load", {29'h0, state}, {29'h0, LOAD});
    sh0 = shift_cnt;
    load_words(8'h10, TOTAL_WORDS);
    tick(2);
    check("abort_reload_shifts", shift_cnt - sh0, TOTAL_WORDS);
    check("abort_reload_solve", {29'h0, state}, {29'h0, SOLVE});
    do_report('{32'hCAFE0001, 1, 1'b0, 8'h00}, "abort_rep");

    // Reset in the middle of LOAD
    send_byte(START_BYTE_DEF);
    load_words(8'h30, 1);
    send_byte(8'h77);
    send_byte(8'h88);
    n_rst = 1'b0;
    tick(3);
    check_reset_outputs("midrst");
    n_rst = 1'b1;
    tick(1);
    s0  = start_cnt;
    sh0 = shift_cnt;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)));
    tick(3);
    check("midrst_no_shift", shift_cnt - sh0, 32'd0);
    check("midrst_no_start", start_cnt - s0, 32'd0);
    check("midrst_idle", {29'h0, state}, {29'h0, IDLE});

`ifdef WORK_TIMEOUT_EN
    // Inter-byte timeout drops a partial word back to IDLE
    sh0 = shift_cnt;
    send_byte(START_BYTE_DEF);
    send_byte(8'h01);
    send_byte(8'h02);
    tick(20);
    check("tmo_idle", {29'h0, state}, {29'h0, IDLE});
    check("tmo_no_shift", shift_cnt - sh0, 32'd0);
    check("tmo_busy", {31'h0, busy}, 32'd0);
    s0 = start_cnt;
    send_byte(START_BYTE_DEF);
    tick(1);
    check("tmo_restart", start_cnt - s0, 32'd1);
    load_words(8'h20, TOTAL_WORDS);
    tick(2);
    check("tmo_reload_solve", {29'h0, state}, {29'h0, SOLVE});
    do_report('{32'h0BADF00D, 0, 1'b0, 8'h00}, "tmo_rep");
`endif

    tick(5);
    check("final_words_left", exp_q.size(), 32'd0);
    check("final_tx_left", exp_tx_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
